// File: rtl/fetch_pkg.sv
// Shared types and constants for the buffered instruction-fetch stage.
// The entry struct is sized for the default 32-bit build; wider builds supply their own entry type.
package fetch_pkg;

  localparam int unsigned DEFAULT_XLEN = 32;
  localparam int unsigned INST_BYTES   = 4;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [DEFAULT_XLEN-1:0] pc;
    logic [DEFAULT_XLEN-1:0] pc_inc;
    logic [31:0]             inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries; flush empties it and overrides push/pop.
// The head is read straight from registered storage.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter type         entry_t = fetch_entry_t,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  entry_t                 push_data,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage is cleared only on reset so the head reads zero out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_buffered.sv
// Instruction-fetch stage: one outstanding imem request, queued delivery to decode,
// redirect with flush and discard of any in-flight response.
module fetch_buffered
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int unsigned     QUEUE_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_redirect,
  input  logic [XLEN-1:0]                i_redirect_pc,
  output logic                           o_imem_req_valid,
  output logic [XLEN-1:0]                o_imem_addr,
  input  logic                           i_imem_req_ready,
  input  logic                           i_imem_rsp_valid,
  input  logic [31:0]                    i_imem_rsp_data,
  output logic                           o_fetch_valid,
  input  logic                           i_decode_ready,
  output logic [XLEN-1:0]                o_fetch_pc,
  output logic [XLEN-1:0]                o_fetch_pc_inc,
  output logic [31:0]                    o_fetch_inst,
  output logic [$clog2(QUEUE_DEPTH):0]   o_queue_count
);

  localparam int unsigned     CW      = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(INST_BYTES);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_inc;
    logic [31:0]     inst;
  } entry_t;

  fetch_state_t    state;
  fetch_state_t    state_nxt;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic            req_hs;
  logic            q_push;
  logic            q_pop;
  logic            q_full;
  logic            q_empty;
  logic [CW-1:0]   q_count;
  entry_t          q_in;
  entry_t          q_head;
  logic            after_reset;
  logic            unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^i_redirect_pc[1:0];

  // Full check alone suffices: count cannot grow while a request is outstanding.
  assign o_imem_req_valid = (state == REQ) && !q_full;
  assign req_hs           = o_imem_req_valid && i_imem_req_ready;
  assign o_imem_addr      = fetch_pc;

  always_comb begin
    state_nxt = state;
    q_push    = 1'b0;
    case (state)
      REQ: begin
        if (req_hs) state_nxt = i_redirect ? DROP : WAIT;
      end
      WAIT: begin
        if (i_imem_rsp_valid) begin
          state_nxt = REQ;
          q_push    = !i_redirect;
        end else if (i_redirect) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (i_imem_rsp_valid) state_nxt = REQ;
      end
      default: state_nxt = REQ;
    endcase
  end

  always_comb begin
    q_in        = '0;
    q_in.pc     = req_pc;
    q_in.pc_inc = req_pc + PC_STEP;
    q_in.inst   = i_imem_rsp_data;
  end

  assign q_pop = o_fetch_valid && i_decode_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= REQ;
      fetch_pc    <= RESET_PC;
      req_pc      <= '0;
      after_reset <= 1'b1;
    end else begin
      state <= state_nxt;
      if (i_redirect) begin
        fetch_pc <= {i_redirect_pc[XLEN-1:2], 2'b00};
      end else if (req_hs) begin
        fetch_pc <= fetch_pc + PC_STEP;
      end
      if (req_hs) begin
        req_pc      <= fetch_pc;
        after_reset <= 1'b0;
      end
    end
  end

  // A stale response may still land after a mid-transaction reset; only flag it afterwards.
  always_ff @(posedge clk) begin
    if (!reset && !after_reset) begin
      assert (!(state == REQ && i_imem_rsp_valid));
    end
  end

  fetch_queue #(
    .entry_t (entry_t),
    .DEPTH   (QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (i_redirect),
    .push      (q_push),
    .pop       (q_pop),
    .push_data (q_in),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign o_fetch_valid  = !q_empty;
  assign o_fetch_pc     = q_head.pc;
  assign o_fetch_pc_inc = q_head.pc_inc;
  assign o_fetch_inst   = q_head.inst;
  assign o_queue_count  = q_count;

endmodule

// File: tb/tb_fetch_buffered.sv
// Directed bench for fetch_buffered: reset vector, back-pressure, stalls, redirects, wrap.
module tb_fetch_buffered;

  localparam int unsigned XLEN = 32;
  localparam int unsigned QD   = 4;
  localparam int unsigned CW   = $clog2(QD) + 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            i_redirect = 1'b0;
  logic [XLEN-1:0] i_redirect_pc = '0;
  logic            o_imem_req_valid;
  logic [XLEN-1:0] o_imem_addr;
  logic            i_imem_req_ready = 1'b1;
  logic            i_imem_rsp_valid = 1'b0;
  logic [31:0]     i_imem_rsp_data = '0;
  logic            o_fetch_valid;
  logic            i_decode_ready = 1'b1;
  logic [XLEN-1:0] o_fetch_pc;
  logic [XLEN-1:0] o_fetch_pc_inc;
  logic [31:0]     o_fetch_inst;
  logic [CW-1:0]   o_queue_count;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  fetch_buffered #(
    .XLEN        (XLEN),
    .RESET_PC    (32'h0000_0100),
    .QUEUE_DEPTH (QD)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .i_redirect       (i_redirect),
    .i_redirect_pc    (i_redirect_pc),
    .o_imem_req_valid (o_imem_req_valid),
    .o_imem_addr      (o_imem_addr),
    .i_imem_req_ready (i_imem_req_ready),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rsp_data  (i_imem_rsp_data),
    .o_fetch_valid    (o_fetch_valid),
    .i_decode_ready   (i_decode_ready),
    .o_fetch_pc       (o_fetch_pc),
    .o_fetch_pc_inc   (o_fetch_pc_inc),
    .o_fetch_inst     (o_fetch_inst),
    .o_queue_count    (o_queue_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    chk(tag, 32'(obs), 32'(exp));
  endtask

  task automatic chkc(input string tag, input logic [CW-1:0] obs, input int unsigned exp);
    chk(tag, 32'(obs), exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept the pending request this cycle, answer it one cycle later.
  task automatic mem_txn(input logic [31:0] data);
    step();
    i_imem_rsp_valid = 1'b1;
    i_imem_rsp_data  = data;
    step();
    i_imem_rsp_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    step();
    step();
    chkb("rst_fetch_valid", o_fetch_valid, 1'b0);
    chk ("rst_fetch_pc", o_fetch_pc, 32'h0);
    chk ("rst_fetch_pc_inc", o_fetch_pc_inc, 32'h0);
    chk ("rst_fetch_inst", o_fetch_inst, 32'h0);
    chkc("rst_count", o_queue_count, 0);
    reset = 1'b0;
    #1;
    chkb("rst_req_valid", o_imem_req_valid, 1'b1);
    chk ("rst_addr", o_imem_addr, 32'h100);

    // Reset vector, k=1, decode always ready: one instruction per two cycles
    for (int i = 0; i < 3; i++) begin
      chkb("rv_req_valid", o_imem_req_valid, 1'b1);
      chk ("rv_addr", o_imem_addr, 32'h100 + 32'(4 * i));
      mem_txn(32'hA000_0000 + 32'(i));
      chkb("rv_fetch_valid", o_fetch_valid, 1'b1);
      chk ("rv_pc", o_fetch_pc, 32'h100 + 32'(4 * i));
      chk ("rv_pc_inc", o_fetch_pc_inc, 32'h104 + 32'(4 * i));
      chk ("rv_inst", o_fetch_inst, 32'hA000_0000 + 32'(i));
      chkc("rv_count", o_queue_count, 1);
    end

    // Redirect to 0 from REQ without handshake, then fill the queue under back-pressure
    i_imem_req_ready = 1'b0;
    i_decode_ready   = 1'b0;
    i_redirect       = 1'b1;
    i_redirect_pc    = 32'h0;
    step();
    i_redirect = 1'b0;
    chkc("bp_flush_count", o_queue_count, 0);
    chkb("bp_flush_valid", o_fetch_valid, 1'b0);
    chk ("bp_flush_addr", o_imem_addr, 32'h0);
    i_imem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chkb("bp_req_valid", o_imem_req_valid, 1'b1);
      mem_txn(32'hB000_0000 + 32'(i));
      chkc("bp_count", o_queue_count, i + 1);
    end
    chkb("bp_full_no_req", o_imem_req_valid, 1'b0);
    step();
    chkb("bp_full_hold_req", o_imem_req_valid, 1'b0);
    chkc("bp_full_hold_count", o_queue_count, 4);
    i_decode_ready = 1'b1;
    chk ("bp_head0", o_fetch_pc, 32'h0);
    chk ("bp_head0_inst", o_fetch_inst, 32'hB000_0000);
    step();
    chkc("bp_count_after_pop", o_queue_count, 3);
    chk ("bp_head1", o_fetch_pc, 32'h4);
    chkb("bp_resume_req", o_imem_req_valid, 1'b1);
    chk ("bp_resume_addr", o_imem_addr, 32'h10);
    step();
    chk ("bp_head2", o_fetch_pc, 32'h8);
    chkb("bp_wait_no_req", o_imem_req_valid, 1'b0);
    i_imem_rsp_valid = 1'b1;
    i_imem_rsp_data  = 32'hB000_0004;
    step();
    i_imem_rsp_valid = 1'b0;
    chkc("bp_push_pop_count", o_queue_count, 2);
    chk ("bp_head3", o_fetch_pc, 32'hC);
    chk ("bp_head3_inst", o_fetch_inst, 32'hB000_0003);
    step();
    chk ("bp_head4", o_fetch_pc, 32'h10);
    chk ("bp_head4_inst", o_fetch_inst, 32'hB000_0004);

    // Redirect while a request to 0x14 is outstanding: stale response dropped
    i_redirect     = 1'b1;
    i_redirect_pc  = 32'h2003;
    i_decode_ready = 1'b0;
    step();
    i_redirect = 1'b0;
    chkc("rd_flush_count", o_queue_count, 0);
    chkb("rd_flush_valid", o_fetch_valid, 1'b0);
    chkb("rd_drop_no_req", o_imem_req_valid, 1'b0);
    step();
    chkb("rd_drop_hold", o_imem_req_valid, 1'b0);
    i_imem_rsp_valid = 1'b1;
    i_imem_rsp_data  = 32'hDEAD_BEEF;
    step();
    i_imem_rsp_valid = 1'b0;
    chkc("rd_stale_count", o_queue_count, 0);
    chkb("rd_stale_valid", o_fetch_valid, 1'b0);
    chkb("rd_req_valid", o_imem_req_valid, 1'b1);
    chk ("rd_addr", o_imem_addr, 32'h2000);

    // Request stall for three cycles, then latency k=5
    i_imem_req_ready = 1'b0;
    i_decode_ready   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chkb("st_req_valid", o_imem_req_valid, 1'b1);
      chk ("st_addr_stable", o_imem_addr, 32'h2000);
    end
    i_imem_req_ready = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      chkb("st_wait_no_req", o_imem_req_valid, 1'b0);
      chkc("st_wait_count", o_queue_count, 0);
      step();
    end
    i_imem_rsp_valid = 1'b1;
    i_imem_rsp_data  = 32'hC000_0001;
    step();
    i_imem_rsp_valid = 1'b0;
    chkb("st_fetch_valid", o_fetch_valid, 1'b1);
    chk ("st_pc", o_fetch_pc, 32'h2000);
    chk ("st_pc_inc", o_fetch_pc_inc, 32'h2004);
    chk ("st_inst", o_fetch_inst, 32'hC000_0001);
    chkc("st_count", o_queue_count, 1);
    chk ("st_next_addr", o_imem_addr, 32'h2004);

    // Redirect in the same cycle as a response and a decode pop
    i_decode_ready = 1'b0;
    step();
    chkc("rr_pre_count", o_queue_count, 1);
    i_imem_rsp_valid = 1'b1;
    i_imem_rsp_data  = 32'hBAD0_0BAD;
    i_redirect       = 1'b1;
    i_redirect_pc    = 32'h3000;
    i_decode_ready   = 1'b1;
    step();
    i_imem_rsp_valid = 1'b0;
    i_redirect       = 1'b0;
    chkc("rr_count", o_queue_count, 0);
    chkb("rr_fetch_valid", o_fetch_valid, 1'b0);
    chkb("rr_req_valid", o_imem_req_valid, 1'b1);
    chk ("rr_addr", o_imem_addr, 32'h3000);

    // PC wrap at the top of the address space
    i_imem_req_ready = 1'b0;
    i_redirect       = 1'b1;
    i_redirect_pc    = 32'hFFFF_FFFF;
    step();
    i_redirect = 1'b0;
    chk ("wr_addr", o_imem_addr, 32'hFFFF_FFFC);
    i_imem_req_ready = 1'b1;
    mem_txn(32'hE000_0007);
    chk ("wr_pc", o_fetch_pc, 32'hFFFF_FFFC);
    chk ("wr_pc_inc", o_fetch_pc_inc, 32'h0);
    chk ("wr_inst", o_fetch_inst, 32'hE000_0007);
    chk ("wr_next_addr", o_imem_addr, 32'h0);

    // Redirect in REQ coinciding with a handshake: that response is dropped
    i_redirect    = 1'b1;
    i_redirect_pc = 32'h40;
    step();
    i_redirect = 1'b0;
    chkb("rh_drop_no_req", o_imem_req_valid, 1'b0);
    chkc("rh_count", o_queue_count, 0);
    i_imem_rsp_valid = 1'b1;
    i_imem_rsp_data  = 32'h1111_1111;
    step();
    i_imem_rsp_valid = 1'b0;
    chkb("rh_req_valid", o_imem_req_valid, 1'b1);
    chk ("rh_addr", o_imem_addr, 32'h40);
    chkb("rh_fetch_valid", o_fetch_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_buffered.md
# fetch_buffered

Parametrised instruction-fetch stage with a synchronous request/response instruction-memory port, a QUEUE_DEPTH-entry instruction queue, and valid/ready delivery to decode. It sits between the instruction memory and decode, replacing the fixed single-register fetch path. It adds:
- a configurable reset vector;
- variable-latency memory support;
- redirect with flush and discard of any in-flight response;
- back-pressure from decode.

## Interface
- XLEN, 32, address/PC width (32 or 64)
- RESET_PC, 0, PC after reset (low two bits must be 0)
- QUEUE_DEPTH, 4, instruction-queue entries (power of two, ≥2)
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- i_redirect  input  1  redirect request from execute (branch/jump taken)
- i_redirect_pc  input  XLEN  redirect target; bits [1:0] ignored and treated as 0
- o_imem_req_valid  output  1  request valid
- o_imem_addr  output  XLEN  request address (current fetch PC)
- i_imem_req_ready  input  1  memory accepts request
- i_imem_rsp_valid  input  1  response valid (exactly one per accepted request)
- i_imem_rsp_data  input  32  instruction word
- o_fetch_valid  output  1  queue head valid
- i_decode_ready  input  1  decode consumes head
- o_fetch_pc  output  XLEN  head PC
- o_fetch_pc_inc  output  XLEN  head PC + 4, mod 2^XLEN
- o_fetch_inst  output  32  head instruction
- o_queue_count  output  $clog2(QUEUE_DEPTH)+1  occupied entries

## Operation
- FSM states: REQ, WAIT, DROP.
- **REQ**
  - o_imem_req_valid = 1 when (count + 0) < QUEUE_DEPTH. At most one request is outstanding.
  - On handshake (valid & ready): fetch_pc <= fetch_pc + 4; next state WAIT.
- **WAIT**
  - o_imem_req_valid = 0.
  - On i_imem_rsp_valid: enqueue {addr of request, addr+4, data}; next state REQ.
- **DROP**
  - An outstanding response belongs to a flushed path.
  - On i_imem_rsp_valid: discard it; next state REQ.
- **Request address**
  - The PC of the request is held in an internal req_pc register.
  - o_imem_addr = fetch_pc, stable while o_imem_req_valid is high and not accepted.
- **Dequeue:** when o_fetch_valid & i_decode_ready.
- **Enqueue and dequeue in the same cycle:** both occur; count is unchanged.
- **Redirect** (highest priority, takes effect at the clock edge):
  - Queue flushed: count <= 0, o_fetch_valid low next cycle. Any dequeue that cycle is ignored.
  - fetch_pc <= {i_redirect_pc[XLEN-1:2], 2'b00}.
  - If in REQ without handshake this cycle: stay REQ.
  - If REQ with handshake this cycle, WAIT without rsp, or DROP without rsp: next state DROP.
  - If WAIT or DROP with i_imem_rsp_valid this cycle: the response is discarded; next state REQ.
  - o_imem_req_valid is not gated by i_redirect combinationally.
- **Full:** no request is issued while count == QUEUE_DEPTH. An accepted request always has a slot reserved, because count cannot grow while outstanding.
- **Wrap-around:** PC + 4 wraps modulo 2^XLEN. Queue pointers wrap modulo QUEUE_DEPTH.
- **Protocol assertion:** i_imem_rsp_valid while in REQ is a protocol error and is ignored.

## Timing
- **Reset:**
  - State REQ, fetch_pc = RESET_PC, count = 0, pointers 0.
  - o_fetch_valid = 0; o_fetch_pc, o_fetch_pc_inc and o_fetch_inst = 0.
  - o_imem_req_valid asserts the first cycle after reset deasserts.
  - Reset mid-transaction: the outstanding response arriving after reset is ignored (state REQ). The memory must be reset together with this block.
- **Latency:** request accepted in cycle N, response in cycle N+k (k≥1) → entry visible on o_fetch_valid in cycle N+k+1.
- **Throughput:** next request is issued in cycle N+k+1. Peak throughput is 1 instruction per 2 cycles with k=1.
- **Output registers:** o_fetch_* are read from queue storage (registered). No combinational path from imem or redirect to o_fetch_*.
- **Redirect:** first redirected request in the cycle after redirect (from REQ), or the cycle after the dropped response (from DROP).

## Structure
- **Package fetch_pkg:**
  - typedef fetch_state_t {REQ, WAIT, DROP}.
  - typedef struct fetch_entry_t {pc, pc_inc, inst}, parametrised via XLEN localparam or package parameter.
  - Constant INST_BYTES = 4.
- **Sub-module fetch_queue:**
  - Generic synchronous FIFO of fetch_entry_t.
  - Ports: clk, reset, flush, push, pop, head, count, full, empty.
  - Flush has priority over push and pop.
- Top level holds the FSM, fetch_pc and req_pc.

## Test plan
- **Reset vector:** RESET_PC=0x100, memory k=1, decode always ready → requests at 0x100, 0x104, 0x108. Outputs o_fetch_pc=0x100, o_fetch_pc_inc=0x104, correct inst, one per 2 cycles.
- **Back-pressure:** QUEUE_DEPTH=4, i_decode_ready=0 → exactly 4 requests. Then o_imem_req_valid=0 with o_queue_count=4. Raising ready → head order 0x0, 0x4, 0x8, 0xC and fetching resumes.
- **Variable latency / req stall:** i_imem_req_ready low 3 cycles, then k=5 → o_imem_addr stable during stall, single entry enqueued, no duplicate request.
- **Redirect while outstanding:** redirect to 0x2003 in WAIT → DROP. Stale response discarded, queue empty, next request 0x2000, head pc 0x2000 / pc_inc 0x2004.
- **Redirect same cycle as response and decode pop:** response data and the pop both ignored. count=0, next request at the redirect target in the following cycle.
- **Wrap:** XLEN=32, redirect to 0xFFFFFFFC → entry pc_inc=0x00000000, next request addr 0x00000000.
